// File: rtl/pulsos_botones_if.sv
`default_nettype none
// ============================================================================
// Module      : pulsos_botones_if
// Description : Button-to-counter link. Carries the raw push-button levels
//               into the pulse generator and the single-cycle increment /
//               decrement strobes out to the hour/minute counters.
//               master = pulse producer, slave = button source / counter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulsos_botones_if;
    logic btn_arriba;       // raw "up" level, asynchronous, active-high
    logic btn_abajo;        // raw "down" level, asynchronous, active-high
    logic boton_aumenta;    // one-cycle increment strobe
    logic boton_disminuye;  // one-cycle decrement strobe

    modport master (
        input  btn_arriba,
        input  btn_abajo,
        output boton_aumenta,
        output boton_disminuye
    );

    modport slave (
        output btn_arriba,
        output btn_abajo,
        input  boton_aumenta,
        input  boton_disminuye
    );
endinterface
`default_nettype wire

// File: rtl/pulsos_botones.sv
`default_nettype none
// ============================================================================
// Module      : pulsos_botones
// Description : Producer side of the clock-setting buttons. Synchronises and
//               debounces the raw up/down buttons and issues one registered
//               single-cycle strobe per debounced press. Pressing both
//               buttons locks out all strobes until both are released.
//               Optional feature macro: AUTOREPEAT_EN - when defined, a held
//               button repeats its strobe after REPEAT_DELAY cycles and then
//               every REPEAT_PERIOD cycles; when undefined no timer exists.
// Revision    : 1.0 - initial release
// ============================================================================
module pulsos_botones #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic             clk,
    input  logic             reset_n,
    pulsos_botones_if.master bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_hold_up = 2'd1;
    localparam logic [1:0] c_hold_dn = 2'd2;
    localparam logic [1:0] c_lock    = 2'd3;

    // Debounce counter compares against N-1 so the level flips on the N-th
    // consecutive mismatching cycle.
    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_range
        $error("pulsos_botones: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    if (64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1) ||
        64'(REPEAT_DELAY)    > ((64'd1 << CNT_W) - 64'd1) ||
        64'(REPEAT_PERIOD)   > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_width
        $error("pulsos_botones: CNT_W too narrow for the configured cycle counts");
    end

    // ------------------------------------------------------------------------
    // Per-button synchroniser and debouncer. Bit 0 = up, bit 1 = down.
    // ------------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_db;

    assign w_raw = {bus.btn_abajo, bus.btn_arriba};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic             r_meta;
        logic             r_sync;
        logic             r_db;
        logic [CNT_W-1:0] r_cnt;

        // Two-flop synchroniser: the raw level is used nowhere else.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
            end else begin
                r_meta <= w_raw[i];
                r_sync <= r_meta;
            end
        end

        // Debounce: count consecutive disagreeing cycles, any agreement
        // restarts the count; the >= compare keeps it from ever wrapping.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt >= c_deb_last) begin
                r_db  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_db[i] = r_db;
    end

    // ------------------------------------------------------------------------
    // Strobe FSM
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_aumenta;
    logic       r_disminuye;
    logic       w_aumenta_next;
    logic       w_disminuye_next;
    logic       w_repeat_due;

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_timer;
    logic             r_repeating;  // first repeat already issued in this hold

    // The first repeat waits the long delay, later ones the short period.
    assign w_repeat_due = r_repeating ? (r_timer >= c_period_last)
                                      : (r_timer >= c_delay_last);

    // Repeat timer: cleared on state entry, reloaded on every strobe,
    // otherwise counts up and saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer     <= '0;
            r_repeating <= 1'b0;
        end else if (w_state_next != r_state) begin
            r_timer     <= '0;
            r_repeating <= 1'b0;
        end else if (w_aumenta_next || w_disminuye_next) begin
            r_timer     <= '0;
            r_repeating <= 1'b1;
        end else if (r_timer != c_cnt_max) begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    // Without auto-repeat a held button never strobes again.
    assign w_repeat_due = 1'b0;
`endif

    // State and strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_idle;
            r_aumenta   <= 1'b0;
            r_disminuye <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_aumenta   <= w_aumenta_next;
            r_disminuye <= w_disminuye_next;
        end
    end

    // Next state: own-button release has priority over the other button.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (w_db == 2'b11)      w_state_next = c_lock;
                else if (w_db == 2'b01) w_state_next = c_hold_up;
                else if (w_db == 2'b10) w_state_next = c_hold_dn;
            end
            c_hold_up: begin
                if (!w_db[0])     w_state_next = c_idle;
                else if (w_db[1]) w_state_next = c_lock;
            end
            c_hold_dn: begin
                if (!w_db[1])     w_state_next = c_idle;
                else if (w_db[0]) w_state_next = c_lock;
            end
            c_lock: begin
                if (w_db == 2'b00) w_state_next = c_idle;
            end
            default: w_state_next = c_idle;
        endcase
    end

    // Strobe requests: a single button seen from IDLE, or a due repeat while
    // the same button alone stays held. Never both, never in LOCK.
    always_comb begin
        w_aumenta_next   = 1'b0;
        w_disminuye_next = 1'b0;
        case (r_state)
            c_idle: begin
                w_aumenta_next   = (w_db == 2'b01);
                w_disminuye_next = (w_db == 2'b10);
            end
            c_hold_up: w_aumenta_next   = (w_db == 2'b01) && w_repeat_due;
            c_hold_dn: w_disminuye_next = (w_db == 2'b10) && w_repeat_due;
            default: begin
                w_aumenta_next   = 1'b0;
                w_disminuye_next = 1'b0;
            end
        endcase
    end

    assign bus.boton_aumenta   = r_aumenta;
    assign bus.boton_disminuye = r_disminuye;

`ifndef SYNTHESIS
    // The two strobes are mutually exclusive by construction.
    a_exclusive : assert property (@(posedge clk) disable iff (!reset_n)
                                   !(r_aumenta && r_disminuye));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulsos_botones.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulsos_botones
// Description : Self-checking bench for pulsos_botones with short timing
//               (debounce 4, repeat delay 20, repeat period 5). A reference
//               model tracks debounced levels from a sample history and the
//               press/lock rules; strobe cycle lists are also pinned by hand.
//               Cycle k of a test = value seen after the k-th rising edge
//               counted from the first edge that samples the new input.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulsos_botones;

    localparam int DEB = 4;
    localparam int DLY = 20;
    localparam int PER = 5;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DN   = 2;
    localparam int M_LOCK = 3;

    logic clk;
    logic reset_n;
    pulsos_botones_if bus_if();

    pulsos_botones #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DLY),
        .REPEAT_PERIOD   (PER),
        .CNT_W           (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;
    int t0          = 0;
    int up_q[$];
    int dn_q[$];
    int exp_q[$];

    always @(posedge clk) edge_n <= edge_n + 1;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit m_up, m_dn;
    bit s1 [2];
    bit s2 [2];
    bit db [2];
    bit hist [2][DEB];
    int mode, since, n_rep;
    bit autorep;

    initial begin
`ifdef AUTOREPEAT_EN
        autorep = 1'b1;
`else
        autorep = 1'b0;
`endif
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_up = 0; m_dn = 0; mode = M_IDLE; since = 0; n_rep = 0;
            for (int b = 0; b < 2; b++) begin
                s1[b] = 0; s2[b] = 0; db[b] = 0;
                for (int k = 0; k < DEB; k++) hist[b][k] = 0;
            end
        end else begin
            bit want_up, want_dn, all_diff;
            int gap;
            want_up = 0; want_dn = 0;
            since++;
            gap = (n_rep == 0) ? DLY : PER;
            case (mode)
                M_IDLE: begin
                    if (db[0] && db[1]) mode = M_LOCK;
                    else if (db[0]) begin want_up = 1; mode = M_UP; since = 0; n_rep = 0; end
                    else if (db[1]) begin want_dn = 1; mode = M_DN; since = 0; n_rep = 0; end
                end
                M_UP: begin
                    if (!db[0]) mode = M_IDLE;
                    else if (db[1]) mode = M_LOCK;
                    else if (autorep && since == gap) begin want_up = 1; since = 0; n_rep++; end
                end
                M_DN: begin
                    if (!db[1]) mode = M_IDLE;
                    else if (db[0]) mode = M_LOCK;
                    else if (autorep && since == gap) begin want_dn = 1; since = 0; n_rep++; end
                end
                default: if (!db[0] && !db[1]) mode = M_IDLE;
            endcase
            m_up = want_up;
            m_dn = want_dn;
            // Debounced level follows once the last DEB synced samples all disagree.
            for (int b = 0; b < 2; b++) begin
                for (int k = DEB - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = s2[b];
                all_diff = 1;
                for (int k = 0; k < DEB; k++) if (hist[b][k] == db[b]) all_diff = 0;
                if (all_diff) db[b] = hist[b][0];
                s2[b] = s1[b];
            end
            s1[0] = bus_if.btn_arriba;
            s1[1] = bus_if.btn_abajo;
        end
    end

    // Every-cycle comparison against the model, plus strobe logging.
    always @(negedge clk) begin
        vectors++;
        if (bus_if.boton_aumenta !== m_up || bus_if.boton_disminuye !== m_dn) begin
            miscompares++;
            $display("FAIL model_compare t=%0t aumenta=%b expected %b disminuye=%b expected %b",
                     $time, bus_if.boton_aumenta, m_up, bus_if.boton_disminuye, m_dn);
        end
        if (bus_if.boton_aumenta === 1'b1)   up_q.push_back(edge_n - t0);
        if (bus_if.boton_disminuye === 1'b1) dn_q.push_back(edge_n - t0);
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %b expected %b", name, act, exp);
        end
    endtask

    function automatic string q2s(input int q[$]);
        string s;
        s = "{";
        foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
        return {s, " }"};
    endfunction

    task automatic check_q(input string name, input int act[$], input int exp[$]);
        bit bad;
        vectors++;
        bad = (act.size() != exp.size());
        if (!bad) foreach (exp[i]) if (act[i] != exp[i]) bad = 1;
        if (bad) begin
            miscompares++;
            $display("FAIL %s got cycles %s expected %s", name, q2s(act), q2s(exp));
        end
    endtask

    task automatic start_test();
        @(negedge clk);
        #1;
        up_q.delete();
        dn_q.delete();
        t0 = edge_n;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        reset_n = 1'b0;
        bus_if.btn_arriba = 1'b0;
        bus_if.btn_abajo  = 1'b0;
        cycles(3);
        #1;
        check_bit("reset_aumenta", bus_if.boton_aumenta, 1'b0);
        check_bit("reset_disminuye", bus_if.boton_disminuye, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        cycles(5);

        // 1: clean up press held 10 cycles -> single strobe in cycle 7
        start_test();
        bus_if.btn_arriba = 1'b1;
        cycles(10);
        bus_if.btn_arriba = 1'b0;
        cycles(15);
        #1;
        exp_q = '{7};
        check_q("t1_aumenta", up_q, exp_q);
        exp_q.delete();
        check_q("t1_disminuye", dn_q, exp_q);

        // 2: down bouncing every 2 cycles -> never debounced
        start_test();
        for (int i = 0; i < 15; i++) begin
            bus_if.btn_abajo = (i % 2 == 0);
            cycles(2);
        end
        bus_if.btn_abajo = 1'b0;
        cycles(15);
        #1;
        exp_q.delete();
        check_q("t2_disminuye", dn_q, exp_q);
        check_q("t2_aumenta", up_q, exp_q);

        // 3: up held 60 cycles
        start_test();
        bus_if.btn_arriba = 1'b1;
        cycles(60);
        bus_if.btn_arriba = 1'b0;
        cycles(30);
        #1;
        if (autorep) exp_q = '{7, 27, 32, 37, 42, 47, 52, 57, 62};
        else         exp_q = '{7};
        check_q("t3_aumenta", up_q, exp_q);
        exp_q.delete();
        check_q("t3_disminuye", dn_q, exp_q);

        // 4: both pressed -> LOCK; release down only -> still locked
        start_test();
        bus_if.btn_arriba = 1'b1;
        bus_if.btn_abajo  = 1'b1;
        cycles(10);
        bus_if.btn_abajo  = 1'b0;
        cycles(15);
        bus_if.btn_arriba = 1'b0;
        cycles(20);
        #1;
        exp_q.delete();
        check_q("t4_lock_aumenta", up_q, exp_q);
        check_q("t4_lock_disminuye", dn_q, exp_q);
        // then a lone down press behaves normally
        start_test();
        bus_if.btn_abajo = 1'b1;
        cycles(10);
        bus_if.btn_abajo = 1'b0;
        cycles(15);
        #1;
        exp_q = '{7};
        check_q("t4_disminuye", dn_q, exp_q);
        exp_q.delete();
        check_q("t4_aumenta", up_q, exp_q);

        // 5: reset pulsed while up held; re-debounce after release
        start_test();
        bus_if.btn_arriba = 1'b1;
        cycles(15);
        reset_n = 1'b0;
        #1;
        check_bit("t5_reset_aumenta", bus_if.boton_aumenta, 1'b0);
        check_bit("t5_reset_disminuye", bus_if.boton_disminuye, 1'b0);
        cycles(3);
        reset_n = 1'b1;
        up_q.delete();
        dn_q.delete();
        t0 = edge_n;
        cycles(15);
        bus_if.btn_arriba = 1'b0;
        cycles(20);
        #1;
        exp_q = '{7};
        check_q("t5_aumenta", up_q, exp_q);
        exp_q.delete();
        check_q("t5_disminuye", dn_q, exp_q);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
